// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative MIPS DIV/DIVU unit.
//   div_state_e : control FSM states (IDLE, BUSY, DONE)
//   DIV_CYCLES  : number of restoring iterations for a 32-bit divide
//   DIVZ_LO     : quotient returned for a zero divisor
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int          DIV_CYCLES = 32;
    localparam logic [31:0] DIVZ_LO    = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration.
//   rem_i / quo_i : current partial remainder and dividend/quotient register
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : partial remainder and quotient after this iteration
// The pair {rem, quo} is shifted left by one; the bit shifted out of quo
// enters rem, and the freshly produced quotient bit enters quo at bit 0.
// -----------------------------------------------------------------------------
module div_step import div_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           neg;

    // rem < dvs always holds, so shifted < 2*dvs: a WIDTH+1 bit difference
    // has its top bit set exactly when the trial subtraction went negative.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_i};
    assign neg     = trial[WIDTH];

    assign rem_o = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Iterative 32-bit MIPS DIV/DIVU unit for the execute stage. It stalls the
// pipeline from E backwards while a radix-2 restoring division runs, then
// presents HI/LO with valid for one cycle so the instruction can leave E.
// An exception flush abandons any operation in progress.
// Ports:
//   clk        : clock, rising edge
//   resetn     : synchronous reset, active-low
//   start      : DIV/DIVU valid in E (held high while E is stalled)
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   a, b       : dividend / divisor (forwarded rs / rt)
//   flush      : exception flush, aborts the operation
//   stall      : multiply/divide stall to the hazard unit (combinational)
//   valid      : HI/LO valid this cycle
//   lo, hi     : quotient / remainder
// -----------------------------------------------------------------------------
module div_iter_unit import div_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? -v : v;
    endfunction

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        // Defined divide-by-zero result, no iterations needed.
                        state_d = DONE;
                        lo_d    = WIDTH'(DIVZ_LO);
                        hi_d    = a;
                        valid_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WIDTH);
                        rem_d   = '0;
                        quo_d   = magnitude(a, signed_div);
                        dvs_d   = magnitude(b, signed_div);
                        qsign_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_d = signed_div & a[WIDTH-1];
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last iteration: sign-correct straight from the step output.
                    state_d = DONE;
                    lo_d    = apply_sign(step_quo, qsign_q);
                    hi_d    = apply_sign(step_rem, rsign_q);
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything: abandon, and leave HI/LO untouched.
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
        end
    end

    // Datapath working registers: only meaningful while BUSY, no reset needed.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        qsign_q <= qsign_d;
        rsign_q <= rsign_d;
    end

    // Divide-by-zero also stalls for its IDLE cycle, so b does not appear here.
    assign stall = ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
    // A flush arriving in the DONE cycle kills the result presentation.
    assign valid = valid_q & ~flush;
    assign lo    = lo_q;
    assign hi    = hi_q;

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit MIPS DIV/DIVU unit in the execute stage. It is the producer of the execute-stage multiply/divide stall that the hazard unit consumes. The unit holds the pipeline from E backwards while a radix-2 restoring division runs. It then presents HI/LO for one cycle so the instruction can leave E, and it abandons any operation when an exception flush arrives.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `CNT_W`, 6: iteration counter width; must satisfy `2^CNT_W > WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `resetn`, input, 1: synchronous reset, active-low.
- `start`, input, 1: a DIV or DIVU instruction is valid in E; held high while E is stalled.
- `signed_div`, input, 1: 1 = DIV (two's complement), 0 = DIVU.
- `a`, input, WIDTH: dividend (rs value after forwarding).
- `b`, input, WIDTH: divisor (rt value after forwarding).
- `flush`, input, 1: exception flush (`flush_except`); abort the operation.
- `stall`, output, 1: drives the hazard unit's `mut_div_stallE` input; combinational.
- `valid`, output, 1: HI/LO result valid this cycle.
- `lo`, output, WIDTH: quotient.
- `hi`, output, WIDTH: remainder.

## Operation
- **FSM states:** IDLE, BUSY, DONE. Reset (`resetn`=0 at edge) forces IDLE, counter=0, `lo`=0, `hi`=0, `valid`=0; `stall`=0 during and after reset.
- **IDLE, start=1, flush=0:**
  - Latch the magnitudes |a| and |b| (unsigned if `signed_div`=0).
  - Latch the quotient sign as `a[31]^b[31]` and the remainder sign as `a[31]`; both signs are forced to 0 for DIVU.
  - Clear the partial remainder, set counter=WIDTH, go to BUSY.
- **IDLE, start=1, b=0:** skip BUSY and go directly to DONE with `lo`=32'hFFFF_FFFF and `hi`=a. This is the defined divide-by-zero result for both DIV and DIVU.
- **BUSY:**
  - Each cycle performs one restoring step on the {remainder, dividend} shift register.
  - Shift left 1 and trial-subtract the divisor on WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
  - Decrement the counter. When the counter reaches 1, the step completes and the state moves to DONE.
- **Sign fix on BUSY→DONE:**
  - `lo` = quotient sign ? −q : q.
  - `hi` = remainder sign ? −r : r.
  - Corner case: 0x8000_0000 / 0xFFFF_FFFF (DIV) gives `lo`=0x8000_0000, `hi`=0.
- **DONE:** `valid`=1 and `stall`=0; E advances this cycle. `start` is ignored in DONE. The next state is always IDLE. `lo`/`hi` hold their values until the next DONE.
- **stall equation:** `stall` = ~flush & ((IDLE & start & b≠0) | (IDLE & start & b=0) | BUSY). This reduces to ~flush & ((IDLE & start) | BUSY).
- **flush=1 in any state:**
  - The next state is IDLE and `stall`=0 in the same cycle.
  - `valid` is forced to 0 in that cycle; `lo`/`hi` are not updated.
  - flush takes priority over `start`.
- **Back-to-back divides:** the second `start` is seen in the IDLE cycle after DONE, with no lost cycle beyond the DONE cycle.

## Timing
- **Cycle 0:** IDLE with start; `stall`=1.
- **Cycles 1–32:** BUSY; `stall`=1.
- **Cycle 33:** DONE; `valid`=1, `stall`=0.
- Total stall is 33 cycles and latency from start to valid is 33 cycles.
- **Divide-by-zero:** `stall`=1 in cycle 0 and DONE in cycle 1, giving a latency of 1 cycle.
- **Registers:** `valid`, `lo`, `hi`, the state and the counter are registered. `stall` is combinational from the state, `start` and `flush`, with no other combinational path.
- **Reset mid-operation:** synchronous reset to IDLE at the next edge; no result is produced.

## Structure
- **Shared package** (`div_pkg`):
  - the state enum {IDLE, BUSY, DONE};
  - `DIV_CYCLES`=32;
  - the divide-by-zero result constants `DIVZ_LO`=32'hFFFF_FFFF.
- **Sub-module** `div_step`: one combinational restoring iteration. It takes the {rem, quo} pair and the divisor and returns the next {rem, quo}. It is instantiated once; the FSM, counter and sign fix stay in `div_iter_unit`.

## Test plan
1. **DIVU, 100 / 7:** start for 34 cycles → `stall`=1 for exactly 33 cycles, then `valid`=1 for 1 cycle with `lo`=14, `hi`=2.
2. **DIV signs:** DIV −7 / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
3. **Divide-by-zero:** DIVU 5 / 0 → `stall` high 1 cycle, then `valid`=1 with `lo`=0xFFFF_FFFF, `hi`=5.
4. **Flush mid-operation:** flush at BUSY cycle 10 → `stall`=0 that cycle, IDLE next cycle, `valid` never asserts, `lo`/`hi` unchanged. A following DIVU 9/3 completes normally with `lo`=3, `hi`=0.
5. **Back-to-back:** DIVU 10/3 then DIVU 20/6 → two `valid` pulses 34 cycles apart with (`lo`,`hi`)=(3,1) then (3,2).
6. **Reset mid-operation:** `resetn`=0 during BUSY → next cycle `stall`=0, `valid`=0, `lo`=`hi`=0.
